instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/flopr.sv | 19 +
 rtl/instr_fetch.sv | 89 ++++++++
 tb/tb_instr_fetch.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned PC_WIDTH  = 64;
   localparam int unsigned IMEM_AW   = 6;
   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned COUNT_W   = 32;

   localparam logic [INSTR_W-1:0] HALT_WORD = 32'hb400001f;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   // Saturating increment for the accepted-instruction counter.
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      sat_inc = (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
   endfunction

endpackage

// File: rtl/flopr.sv
// Parameterised-width flip-flop with asynchronous active-high reset to zero and load enable.
module flopr #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, next-PC selection, IF/ID pipeline register and halt detection.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned N = PC_WIDTH
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall_D,
   input  logic         branch_taken,
   input  logic [N-1:0] branch_target,
   output logic [5:0]   imem_addr,
   input  logic [31:0]  imem_q,
   output logic [31:0]  instr_D,
   output logic [N-1:0] pc_D,
   output logic         valid_D,
   output logic         halted,
   output logic [31:0]  fetch_count
);

   fetch_state_t state;
   logic [N-1:0] pc;
   logic [N-1:0] pc_next;
   logic         pc_en;
   logic         is_halt;
   logic         unused_target_lsbs;

   // Branch targets are forced word-aligned, so the low two bits never matter.
   assign unused_target_lsbs = ^branch_target[1:0];

   assign imem_addr = pc[7:2];
   assign is_halt   = (imem_q == HALT_WORD);

   // Next-PC selection: redirect beats stall; the halt word freezes the PC on itself.
   always_comb begin
      pc_next = pc + N'(4);
      pc_en   = 1'b0;
      if (state == RUN) begin
         if (branch_taken) begin
            pc_next = {branch_target[N-1:2], 2'b00};
            pc_en   = 1'b1;
         end else if (!stall_D && !is_halt) begin
            pc_en   = 1'b1;
         end
      end
   end

   flopr #(.WIDTH(N)) u_pc (
      .clk   (clk),
      .reset (reset),
      .en    (pc_en),
      .d     (pc_next),
      .q     (pc)
   );

   // FSM plus IF/ID register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         instr_D     <= '0;
         pc_D        <= '0;
         valid_D     <= 1'b0;
         halted      <= 1'b0;
         fetch_count <= '0;
      end else if (state == RUN) begin
         if (branch_taken) begin
            instr_D <= '0;
            pc_D    <= '0;
            valid_D <= 1'b0;
         end else if (!stall_D) begin
            instr_D     <= imem_q;
            pc_D        <= pc;
            valid_D     <= 1'b1;
            fetch_count <= sat_inc(fetch_count);
            if (is_halt) begin
               state  <= HALT;
               halted <= 1'b1;
            end
         end
      end else begin
         // Drain the halt word once decode is ready; only reset leaves HALT.
         if (!stall_D) begin
            instr_D <= '0;
            valid_D <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a behavioural 64-word instruction ROM.
module tb_instr_fetch;

   localparam int unsigned N = 64;

   logic         clk;
   logic         reset;
   logic         stall_D;
   logic         branch_taken;
   logic [N-1:0] branch_target;
   logic [5:0]   imem_addr;
   logic [31:0]  imem_q;
   logic [31:0]  instr_D;
   logic [N-1:0] pc_D;
   logic         valid_D;
   logic         halted;
   logic [31:0]  fetch_count;

   logic [31:0]  rom [64];

   int checks = 0;
   int errors = 0;

   instr_fetch #(.N(N)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall_D       (stall_D),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_q        (imem_q),
      .instr_D       (instr_D),
      .pc_D          (pc_D),
      .valid_D       (valid_D),
      .halted        (halted),
      .fetch_count   (fetch_count)
   );

   assign imem_q = rom[imem_addr];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [5:0] a, input logic [31:0] ins,
                          input logic [N-1:0] p, input logic v, input logic h,
                          input logic [31:0] fc);
      chk({tag, ".imem_addr"},   64'(imem_addr),   64'(a));
      chk({tag, ".instr_D"},     64'(instr_D),     64'(ins));
      chk({tag, ".pc_D"},        64'(pc_D),        64'(p));
      chk({tag, ".valid_D"},     64'(valid_D),     64'(v));
      chk({tag, ".halted"},      64'(halted),      64'(h));
      chk({tag, ".fetch_count"}, 64'(fetch_count), 64'(fc));
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'h91000000 | 32'(i);
      rom[0]  = 32'hf8000001;
      rom[1]  = 32'hf8008002;
      rom[46] = 32'hb400001f;

      reset         = 1'b1;
      stall_D       = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;

      // Reset state
      #12;
      chk_all("reset", 6'd0, 32'h0, '0, 1'b0, 1'b0, 32'd0);
      reset = 1'b0;
      #1;
      chk("release.imem_addr", 64'(imem_addr), 64'd0);

      // Sequential fetch
      step();
      chk_all("fetch0", 6'd1, 32'hf8000001, 64'h0, 1'b1, 1'b0, 32'd1);
      step();
      chk_all("fetch1", 6'd2, 32'hf8008002, 64'h4, 1'b1, 1'b0, 32'd2);

      // Stall holds everything for three cycles
      stall_D = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all("stall", 6'd2, 32'hf8008002, 64'h4, 1'b1, 1'b0, 32'd2);
      end
      stall_D = 1'b0;
      step();
      chk_all("resume", 6'd3, 32'h91000002, 64'h8, 1'b1, 1'b0, 32'd3);

      // Branch wins over stall, target is word-aligned, IF/ID flushed
      branch_taken  = 1'b1;
      branch_target = 64'h43;
      stall_D       = 1'b1;
      step();
      chk_all("branch", 6'h10, 32'h0, 64'h0, 1'b0, 1'b0, 32'd3);
      branch_taken = 1'b0;
      stall_D      = 1'b0;

      // Run words 16..45 then capture the halt word at 0xB8
      for (int i = 0; i < 30; i++) step();
      chk_all("pre_halt", 6'd46, 32'h9100002d, 64'hb4, 1'b1, 1'b0, 32'd33);
      step();
      chk_all("halt", 6'd46, 32'hb400001f, 64'hb8, 1'b1, 1'b1, 32'd34);

      // Halted and stalled: branch ignored, IF/ID held
      stall_D       = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 64'h20;
      step();
      chk_all("halt_stall_br", 6'd46, 32'hb400001f, 64'hb8, 1'b1, 1'b1, 32'd34);
      step();
      chk_all("halt_stall2", 6'd46, 32'hb400001f, 64'hb8, 1'b1, 1'b1, 32'd34);

      // Asynchronous reset while halted with valid IF/ID
      #2 reset = 1'b1;
      #1;
      chk_all("async_reset", 6'd0, 32'h0, 64'h0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      reset        = 1'b0;
      stall_D      = 1'b0;
      branch_taken = 1'b0;
      step();
      chk_all("after_reset", 6'd1, 32'hf8000001, 64'h0, 1'b1, 1'b0, 32'd1);

      // Reach halt again, then let the halt word drain with decode ready
      for (int i = 0; i < 45; i++) step();
      step();
      chk_all("halt2", 6'd46, 32'hb400001f, 64'hb8, 1'b1, 1'b1, 32'd47);
      branch_taken  = 1'b1;
      branch_target = 64'h0;
      step();
      chk_all("halt_drain", 6'd46, 32'h0, 64'hb8, 1'b0, 1'b1, 32'd47);
      step();
      chk_all("halt_frozen", 6'd46, 32'h0, 64'hb8, 1'b0, 1'b1, 32'd47);
      branch_taken = 1'b0;

      // Counter saturation
      reset = 1'b1;
      #2;
      @(negedge clk);
      reset   = 1'b0;
      stall_D = 1'b1;
      force dut.fetch_count = 32'hfffffffe;
      @(negedge clk);
      release dut.fetch_count;
      #1;
      chk("sat_preload", 64'(fetch_count), 64'hfffffffe);
      @(negedge clk);
      stall_D = 1'b0;
      step();
      chk("sat_step1", 64'(fetch_count), 64'hffffffff);
      chk("sat_step1.instr_D", 64'(instr_D), 64'hf8000001);
      step();
      chk("sat_step2", 64'(fetch_count), 64'hffffffff);
      step();
      chk("sat_step3", 64'(fetch_count), 64'hffffffff);
      chk("sat_step3.pc_D", 64'(pc_D), 64'h8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
